// File: rtl/latch_pipe_pkg.sv
// latch_pipe_pkg: shared constants, types and
// helpers for the latch_pipe storage chain.
package latch_pipe_pkg;

  localparam MODE_FLOP  = "FLOP";
  localparam MODE_LATCH = "LATCH";

  localparam int MAX_WIDTH = 64;
  localparam int MAX_DEPTH = 16;

  // One stage worth of state at the widest width.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    logic                 valid;
  } stage_t;

  // Bits needed to count 0..depth occupied stages.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Number of set bits in a valid vector.
  function automatic logic [4:0] popcount16(
    input logic [MAX_DEPTH-1:0] v
  );
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/latch_pipe_stage.sv
// latch_pipe_stage: one data+valid stage, built as
// either a rising-edge flop or a level latch.
module latch_pipe_stage
  import latch_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter                   MODE       = MODE_FLOP,
  parameter bit               PHASE      = 1'b0,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  output logic [WIDTH-1:0] Q,
  output logic             QV
);

  // A phase only has meaning for latch stages.
  if (MODE != MODE_LATCH && PHASE) begin : g_bad_phase
    $fatal(1, "latch_pipe_stage: flop has no phase");
  end

  if (MODE == MODE_LATCH) begin : g_latch

    logic open_c;
    logic en;

    // PHASE=0 opens while C is high, PHASE=1 while low.
    assign open_c = PHASE ? ~C : C;
    assign en     = E & open_c;

    // Data latch: follows D while open, else holds.
    always_latch begin
      if (!R) begin
        Q <= INIT_VALUE;
      end else if (en) begin
        Q <= D;
      end
    end

    // Valid latch: a flush clears it at level.
    always_latch begin
      if (!R) begin
        QV <= 1'b0;
      end else if (CLR) begin
        QV <= 1'b0;
      end else if (en) begin
        QV <= DV;
      end
    end

  end else begin : g_flop

    // Data flop: shifts on enable, flush leaves it alone.
    always_ff @(posedge C or negedge R) begin
      if (!R) begin
        Q <= INIT_VALUE;
      end else if (E) begin
        Q <= D;
      end else if (!E) begin
        Q <= Q;
      end else begin
        Q <= 'x;
      end
    end

    // Valid flop: flush wins over enable.
    always_ff @(posedge C or negedge R) begin
      if (!R) begin
        QV <= 1'b0;
      end else if (CLR) begin
        QV <= 1'b0;
      end else if (!CLR && E) begin
        QV <= DV;
      end else if (!CLR && !E) begin
        QV <= QV;
      end else begin
        QV <= 1'bx;
      end
    end

  end

endmodule

// File: rtl/latch_pipe.sv
// latch_pipe: WIDTH x DEPTH flop/latch chain with a
// travelling valid bit, flush and occupancy count.
module latch_pipe
  import latch_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 2,
  parameter                   MODE       = MODE_FLOP,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter real              DLY        = 0.5
) (
  input  logic                        C,
  input  logic                        R,
  input  logic                        E,
  input  logic                        CLR,
  input  logic [WIDTH-1:0]            D,
  input  logic                        DV,
  output logic [WIDTH-1:0]            Q,
  output logic                        QV,
  output logic [cnt_width(DEPTH)-1:0] CNT
);

  localparam int CW = cnt_width(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $fatal(1, "latch_pipe: DEPTH out of range");
  end

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "latch_pipe: WIDTH out of range");
  end

  if (MODE != MODE_FLOP && MODE != MODE_LATCH) begin : g_bad_mode
    $fatal(1, "latch_pipe: MODE must be FLOP or LATCH");
  end

  if (DLY < 0.0) begin : g_bad_dly
    $fatal(1, "latch_pipe: DLY must not be negative");
  end

  // Index 0 is the chain input, index k the output of stage k-1.
  logic [WIDTH-1:0] sd [DEPTH+1];
  logic [DEPTH:0]   sv;

  assign sd[0] = D;
  assign sv[0] = DV;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    latch_pipe_stage #(
      .WIDTH      (WIDTH),
      .MODE       (MODE),
      .PHASE      (MODE == MODE_LATCH && (k % 2) == 1),
      .INIT_VALUE (INIT_VALUE)
    ) u_stage (
      .C   (C),
      .R   (R),
      .E   (E),
      .CLR (CLR),
      .D   (sd[k]),
      .DV  (sv[k]),
      .Q   (sd[k+1]),
      .QV  (sv[k+1])
    );
  end

  assign Q  = sd[DEPTH];
  assign QV = sv[DEPTH];

  // Occupancy: count of stage valids, bounded by DEPTH.
  always_comb begin
    CNT = '0;
    CNT = CW'(popcount16(16'(sv[DEPTH:1])));
  end

`ifdef TIMED_SIM
`ifndef SYNTHESIS
  // D->Q only exists as a real path for one open latch.
  specify
    specparam t_dly = DLY;
    (C *> Q)  = t_dly;
    (C => QV) = t_dly;
    (R *> Q)  = t_dly;
    (D *> Q)  = t_dly;
  endspecify
`endif
`endif

endmodule

// File: tb/tb_latch_pipe.sv
// tb_latch_pipe: directed scoreboard bench for a flop
// chain and two latch chains of latch_pipe.
module tb_latch_pipe;
  import latch_pipe_pkg::*;

  typedef struct {
    int     id;
    longint due;
    string  name;
    stage_t want;
    int     cnt;
  } exp_t;

  typedef struct {
    bit         arst;
    logic       r;
    logic       e;
    logic       clr;
    logic [7:0] d;
    logic       dv;
    logic [7:0] q;
    logic       qv;
    int         cnt;
    string      name;
  } frow_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic       clk;
  logic       f_r, f_e, f_clr, f_dv;
  logic [7:0] f_d, f_q;
  logic       f_qv;
  logic [1:0] f_cnt;

  logic       c1, l1_r, l1_e, l1_clr, l1_dv;
  logic [7:0] l1_d, l1_q;
  logic       l1_qv;
  logic [0:0] l1_cnt;

  logic       c2, l2_r, l2_e, l2_clr, l2_dv;
  logic [7:0] l2_d, l2_q;
  logic       l2_qv;
  logic [1:0] l2_cnt;

  latch_pipe #(
    .WIDTH(8), .DEPTH(3), .MODE("FLOP"),
    .INIT_VALUE(8'h00), .DLY(0.5)
  ) u_flop (
    .C(clk), .R(f_r), .E(f_e), .CLR(f_clr),
    .D(f_d), .DV(f_dv),
    .Q(f_q), .QV(f_qv), .CNT(f_cnt)
  );

  latch_pipe #(
    .WIDTH(8), .DEPTH(1), .MODE("LATCH"),
    .INIT_VALUE(8'h00), .DLY(0.5)
  ) u_lat1 (
    .C(c1), .R(l1_r), .E(l1_e), .CLR(l1_clr),
    .D(l1_d), .DV(l1_dv),
    .Q(l1_q), .QV(l1_qv), .CNT(l1_cnt)
  );

  latch_pipe #(
    .WIDTH(8), .DEPTH(2), .MODE("LATCH"),
    .INIT_VALUE(8'h00), .DLY(0.5)
  ) u_lat2 (
    .C(c2), .R(l2_r), .E(l2_e), .CLR(l2_clr),
    .D(l2_d), .DV(l2_dv),
    .Q(l2_q), .QV(l2_qv), .CNT(l2_cnt)
  );

  frow_t rows [18] = '{
    '{0, 1, 1, 0, 8'h11, 1, 8'h00, 0, 1, "load1"},
    '{0, 1, 1, 0, 8'h22, 1, 8'h00, 0, 2, "load2"},
    '{0, 1, 1, 0, 8'h33, 1, 8'h11, 1, 3, "load3"},
    '{0, 1, 0, 0, 8'h44, 1, 8'h11, 1, 3, "stall1"},
    '{0, 1, 0, 0, 8'h44, 1, 8'h11, 1, 3, "stall2"},
    '{0, 1, 1, 1, 8'h55, 1, 8'h22, 0, 0, "flush"},
    '{0, 1, 1, 0, 8'h66, 1, 8'h33, 0, 1, "refill1"},
    '{0, 1, 1, 0, 8'h77, 0, 8'h55, 0, 1, "bubble"},
    '{0, 1, 1, 0, 8'h88, 1, 8'h66, 1, 2, "refill2"},
    '{0, 1, 1, 1, 8'h99, 1, 8'h77, 0, 0, "clr_dv"},
    '{0, 1, 0, 1, 8'hAA, 1, 8'h77, 0, 0, "clr_hold"},
    '{0, 1, 1, 0, 8'hFF, 1, 8'h88, 0, 1, "ff1"},
    '{0, 1, 1, 0, 8'hFF, 1, 8'h99, 0, 2, "ff2"},
    '{0, 1, 1, 0, 8'hFF, 1, 8'hFF, 1, 3, "ff3"},
    '{1, 0, 1, 0, 8'h12, 1, 8'h00, 0, 0, "async_rst"},
    '{0, 1, 1, 0, 8'h12, 1, 8'h00, 0, 1, "rel1"},
    '{0, 1, 1, 0, 8'h34, 1, 8'h00, 0, 2, "rel2"},
    '{0, 1, 1, 0, 8'h56, 0, 8'h12, 1, 2, "rel3"}
  };

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic expect_at(
    input int         id,
    input longint     due,
    input string      name,
    input logic [7:0] q,
    input logic       qv,
    input int         cnt
  );
    exp_t x;
    x.id         = id;
    x.due        = due;
    x.name       = name;
    x.want.data  = 64'(q);
    x.want.valid = qv;
    x.cnt        = cnt;
    sb.push_back(x);
  endtask

  // Monitor: checks on odd times, stimulus moves on even.
  initial begin
    exp_t       x;
    logic [7:0] aq;
    logic       aqv;
    int         ac;
    #1;
    forever begin
      while (sb.size() > 0 && sb[0].due < $time) begin
        x = sb.pop_front();
        case (x.id)
          0: begin aq = f_q;  aqv = f_qv;  ac = int'(f_cnt);  end
          1: begin aq = l1_q; aqv = l1_qv; ac = int'(l1_cnt); end
          default: begin
            aq = l2_q; aqv = l2_qv; ac = int'(l2_cnt);
          end
        endcase
        n_chk++;
        if (x.want.data === 64'(aq) &&
            x.want.valid === aqv && x.cnt == ac) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got Q=%h QV=%b CNT=%0d, want Q=%h QV=%b CNT=%0d",
                   x.name, aq, aqv, ac, x.want.data[7:0],
                   x.want.valid, x.cnt);
        end
      end
      #2;
    end
  end

  initial begin
    f_r = 1; f_e = 0; f_clr = 0; f_d = 0; f_dv = 0;
    c1 = 0; l1_r = 1; l1_e = 0; l1_clr = 0; l1_d = 0; l1_dv = 0;
    c2 = 0; l2_r = 1; l2_e = 0; l2_clr = 0; l2_d = 0; l2_dv = 0;
    #2;
    f_r = 0; l1_r = 0; l2_r = 0;
    expect_at(0, $time, "f_reset", 8'h00, 0, 0);
    expect_at(1, $time, "l1_reset", 8'h00, 0, 0);
    expect_at(2, $time, "l2_reset", 8'h00, 0, 0);
    @(posedge clk);
    @(posedge clk);

    foreach (rows[i]) begin
      if (rows[i].arst) #6;
      else #2;
      f_r = rows[i].r;
      f_e = rows[i].e;
      f_clr = rows[i].clr;
      f_d = rows[i].d;
      f_dv = rows[i].dv;
      expect_at(0, rows[i].arst ? $time : $time + 20,
                rows[i].name, rows[i].q, rows[i].qv,
                rows[i].cnt);
      @(posedge clk);
    end
    #10;

    l1_r = 1; l1_e = 1;
    #2 c1 = 1;
    #2 l1_d = 8'hA5; l1_dv = 1;
    expect_at(1, $time, "l1_follow_a5", 8'hA5, 1, 1);
    #2 l1_d = 8'h5A;
    expect_at(1, $time, "l1_follow_5a", 8'h5A, 1, 1);
    #2 c1 = 0;
    #2 l1_d = 8'h77; l1_dv = 0;
    expect_at(1, $time, "l1_hold_low", 8'h5A, 1, 1);
    #2 l1_e = 0;
    #2 c1 = 1;
    #2 l1_d = 8'h99;
    expect_at(1, $time, "l1_hold_e0", 8'h5A, 1, 1);
    #2 l1_e = 1;
    expect_at(1, $time, "l1_enable", 8'h99, 0, 0);
    #2 l1_dv = 1;
    expect_at(1, $time, "l1_valid", 8'h99, 1, 1);
    #2 l1_clr = 1;
    expect_at(1, $time, "l1_clr_level", 8'h99, 0, 0);
    #2 c1 = 0;
    #2 l1_clr = 0;
    expect_at(1, $time, "l1_closed", 8'h99, 0, 0);

    #4;
    l2_r = 1; l2_e = 1;
    #2 c2 = 1;
    #2 l2_d = 8'h3C; l2_dv = 1;
    expect_at(2, $time, "l2_s0_open", 8'h00, 0, 1);
    #2 c2 = 0;
    expect_at(2, $time, "l2_s1_open", 8'h3C, 1, 2);
    #2 l2_d = 8'hC3; l2_dv = 0;
    expect_at(2, $time, "l2_low_hold", 8'h3C, 1, 2);
    #2 c2 = 1;
    expect_at(2, $time, "l2_next_high", 8'h3C, 1, 1);
    #2 c2 = 0;
    expect_at(2, $time, "l2_drain", 8'hC3, 0, 0);

    for (int i = 0; i < 100 && sb.size() > 0; i++) #2;
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d checks pending, want 0",
               sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
